// File: rtl/branch_predictor.sv
// branch_predictor
//
// Dynamic branch predictor for the RV32I core: a direct-mapped table of 2-bit saturating
// counters with stored branch targets (BHT+BTB combined). Fetch queries the table with the
// current PC and gets a registered taken/target prediction one cycle later. The execute
// stage trains the table with resolved conditional-branch outcomes.
//
// Ports:
//   clk       in   1   clock, all state changes on the rising edge
//   reset     in   1   asynchronous active-high reset, clears table and outputs
//   q_valid   in   1   fetch query request this cycle
//   q_pc      in   32  PC being fetched, bits [1:0] ignored
//   p_valid   out  1   prediction valid, one cycle after an accepted query
//   p_taken   out  1   predicted taken
//   p_target  out  32  predicted next PC
//   u_valid   in   1   resolved conditional branch this cycle
//   u_pc      in   32  PC of the resolved branch
//   u_taken   in   1   actual outcome from the branch comparator
//   u_target  in   32  branch target, meaningful when u_taken=1
//
// Table layout: index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]. Each entry holds a
// valid bit, a tag, target[31:2] and a 2-bit counter (00 strong-NT .. 11 strong-T).

module branch_predictor #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  // fetch query
  input  logic        q_valid,
  input  logic [31:0] q_pc,
  // registered prediction
  output logic        p_valid,
  output logic        p_taken,
  output logic [31:0] p_target,
  // resolved branch update
  input  logic        u_valid,
  input  logic [31:0] u_pc,
  input  logic        u_taken,
  input  logic [31:0] u_target
);

  localparam int unsigned Entries = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 30 - INDEX_BITS;

  localparam logic [1:0] CtrStrongNt = 2'b00;
  localparam logic [1:0] CtrWeakNt   = 2'b01;
  localparam logic [1:0] CtrWeakT    = 2'b10;
  localparam logic [1:0] CtrStrongT  = 2'b11;

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic               valid_q  [Entries];
  logic [TagBits-1:0] tag_q    [Entries];
  logic [29:0]        target_q [Entries];
  logic [1:0]         ctr_q    [Entries];

  // ---------------------------------------------------------------------------
  // Query path: combinational lookup, result registered into the p_* outputs
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] q_idx;
  logic [TagBits-1:0]    q_tag;
  logic                  q_hit;
  logic                  q_pred_taken;
  logic [31:0]           q_seq_pc;
  logic [31:0]           q_pred_target;

  always_comb begin
    q_idx         = q_pc[INDEX_BITS+1:2];
    q_tag         = q_pc[31:INDEX_BITS+2];
    q_hit         = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
    q_pred_taken  = q_hit && ctr_q[q_idx][1];
    // Fall-through PC; the add wraps naturally at 32 bits.
    q_seq_pc      = {q_pc[31:2], 2'b00} + 32'd4;
    q_pred_target = q_pred_taken ? {target_q[q_idx], 2'b00} : q_seq_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid  <= 1'b0;
      p_taken  <= 1'b0;
      p_target <= 32'd0;
    end else begin
      p_valid <= q_valid;
      // Hold the last prediction when idle; p_taken/p_target are don't-care then.
      if (q_valid) begin
        p_taken  <= q_pred_taken;
        p_target <= q_pred_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Update path: compute the next contents of the addressed entry
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] u_idx;
  logic [TagBits-1:0]    u_tag;
  logic                  u_hit;
  logic [1:0]            u_ctr_inc;
  logic [1:0]            u_ctr_dec;

  logic                  upd_we;
  logic                  upd_valid;
  logic [TagBits-1:0]    upd_tag;
  logic [29:0]           upd_target;
  logic [1:0]            upd_ctr;

  always_comb begin
    u_idx     = u_pc[INDEX_BITS+1:2];
    u_tag     = u_pc[31:INDEX_BITS+2];
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr_inc = (ctr_q[u_idx] == CtrStrongT)  ? CtrStrongT  : ctr_q[u_idx] + 2'd1;
    u_ctr_dec = (ctr_q[u_idx] == CtrStrongNt) ? CtrStrongNt : ctr_q[u_idx] - 2'd1;

    upd_we     = 1'b0;
    upd_valid  = valid_q[u_idx];
    upd_tag    = tag_q[u_idx];
    upd_target = target_q[u_idx];
    upd_ctr    = ctr_q[u_idx];

    if (u_valid) begin
      if (u_hit) begin
        // Train an existing entry; tag and valid stay as they are.
        upd_we  = 1'b1;
        upd_ctr = u_taken ? u_ctr_inc : u_ctr_dec;
        if (u_taken) begin
          upd_target = u_target[31:2];
        end
      end else if (u_taken) begin
        // Allocate (or evict an alias) only for taken branches; a not-taken
        // miss would predict fall-through anyway.
        upd_we     = 1'b1;
        upd_valid  = 1'b1;
        upd_tag    = u_tag;
        upd_target = u_target[31:2];
        upd_ctr    = CtrWeakT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-entry registers. Non-blocking writes give read-before-write for a
  // same-cycle query to the same index with no extra bypass logic.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < Entries; g++) begin : gen_entry
    localparam logic [INDEX_BITS-1:0] EntryIdx = INDEX_BITS'(g);

    logic entry_we;
    assign entry_we = upd_we && (u_idx == EntryIdx);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q[g]  <= 1'b0;
        tag_q[g]    <= '0;
        target_q[g] <= '0;
        ctr_q[g]    <= CtrWeakNt;
      end else if (entry_we) begin
        valid_q[g]  <= upd_valid;
        tag_q[g]    <= upd_tag;
        target_q[g] <= upd_target;
        ctr_q[g]    <= upd_ctr;
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RV32I core: a direct-mapped table of 2-bit saturating counters plus target addresses (BHT+BTB). Fetch queries it with the current PC and receives a registered taken/target prediction one cycle later. The execute stage feeds it resolved conditional-branch outcomes (BEQ/BNE/BLT/BGE/BLTU/BGEU taken flag and target), closing the loop on the branch comparator's result.

## Interface
- INDEX_BITS, 6, log2 of table entries (64); index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears the table and all outputs
- q_valid  input  1  fetch query request this cycle
- q_pc  input  32  PC being fetched; bits [1:0] ignored
- p_valid  output  1  prediction valid (one cycle after accepted query)
- p_taken  output  1  predicted taken
- p_target  output  32  predicted next PC
- u_valid  input  1  resolved conditional branch this cycle
- u_pc  input  32  PC of resolved branch
- u_taken  input  1  actual outcome from branch comparator
- u_target  input  32  branch target (pc + B-immediate), meaningful when u_taken=1

## Operation
- Entry: valid (1), tag (30-INDEX_BITS), target (30, bits [31:2]; [1:0] stored as 00), ctr (2).
- Reset: every valid=0, ctr=2'b01, target=0, tag=0; p_valid=0, p_taken=0, p_target=0.
- Query: hit = entry.valid && entry.tag == q_pc tag. Prediction taken iff hit && ctr[1]. Taken -> p_target = {entry.target, 2'b00}; otherwise p_target = q_pc + 4 (32-bit wrap, 0xFFFFFFFC+4 = 0x00000000), with q_pc[1:0] forced to 0 before adding.
- Update on hit (u_pc tag matches valid entry): ctr saturating +1 if u_taken (max 2'b11), -1 if not (min 2'b00); target overwritten with u_target when u_taken; tag/valid unchanged.
- Update on miss, u_taken=1: allocate/replace entry: valid=1, tag from u_pc, target from u_target, ctr=2'b10.
- Update on miss, u_taken=0: no table change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; transitions only on u_valid.
- No flush input; only reset clears the table.

## Timing
- Query latency 1: q_valid sampled at edge N -> p_valid=1 with p_taken/p_target held from edge N until edge N+1. q_valid=0 at edge N -> p_valid=0 after edge N; p_taken/p_target retain previous values (don't-care when p_valid=0).
- Back-to-back queries every cycle supported; throughput 1/cycle.
- Update writes at the edge where u_valid=1; visible to queries sampled at the following edge or later.
- Same-cycle query and update to the same index: query returns pre-update contents (read-before-write, no bypass).
- Query and update to different indices in the same cycle are independent.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronously), any in-flight prediction dropped; first valid prediction earliest one edge after reset deasserts.

## Test plan
- Reset then query q_pc=0x00000100 -> next cycle p_valid=1, p_taken=0, p_target=0x00000104.
- Update u_pc=0x00000100, u_taken=1, u_target=0x00000080; next cycle query 0x100 -> p_taken=1, p_target=0x00000080 (ctr=10); one not-taken update then query -> p_taken=0, p_target=0x104 (ctr=01).
- Saturation: 5 taken updates on 0x200 then 1 not-taken -> still taken (11->10); 5 not-taken then 1 taken -> not taken (00->01).
- Aliasing: entry allocated at 0x00000100; query 0x00000200 (same index 0, different tag) -> not taken, target 0x204; taken update at 0x200 target 0x40 replaces it -> query 0x100 now misses.
- Same-cycle: query and taken update both at 0x300 on a cold table -> p_taken=0; repeat query next cycle -> p_taken=1. Query 0xFFFFFFFC cold -> p_target=0x00000000.
- Assert reset mid-stream with p_valid=1 -> p_valid/p_taken/p_target=0 without a clock edge; previously trained 0x100 predicts not taken after reset.
